// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter merging EX results with FIFO-buffered LSU loads, plus pending-load scoreboard.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_stall_o,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        pend_set_i,
    input  logic [4:0]  pend_rd_i,
    output logic [31:0] busy_mask_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, empty, ex_req, pop, ex_go, push;
    logic [31:0]   set_mask, clr_mask, busy_next;

    always_comb begin
        full        = count == CW'(DEPTH);
        empty       = count == '0;
        ex_req      = ex_wen_i & (ex_waddr_i != 5'd0);
        pop         = !empty & (full | !ex_req);
        ex_go       = ex_req & !full;
        push        = lsu_valid_i & !full & (lsu_waddr_i != 5'd0);
        ex_stall_o  = ex_wen_i & full;
        lsu_ready_o = !full;
        set_mask    = pend_set_i ? (32'd1 << pend_rd_i) : 32'd0;
        clr_mask    = pop ? (32'd1 << addr_mem[rd_ptr]) : 32'd0;
        busy_next   = ((busy_mask_o & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= lsu_waddr_i;
            data_mem[wr_ptr] <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            busy_mask_o <= '0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            rd_ptr      <= rd_ptr + AW'(pop);
            wr_ptr      <= wr_ptr + AW'(push);
            count       <= count + CW'(push) - CW'(pop);
            busy_mask_o <= busy_next;
            reg_wen_o   <= pop | ex_go;
            if (pop) begin
                reg_waddr_o <= addr_mem[rd_ptr];
                reg_wdata_o <= data_mem[rd_ptr];
            end else if (ex_go) begin
                reg_waddr_o <= ex_waddr_i;
                reg_wdata_o <= ex_wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wen_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        pend_set_i;
    logic [4:0]  pend_rd_i;
    logic [31:0] busy_mask_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    int tests = 0;
    int fails = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_stall_o(ex_stall_o),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .pend_set_i(pend_set_i), .pend_rd_i(pend_rd_i), .busy_mask_o(busy_mask_o),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_wen_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        pend_set_i = 0; pend_rd_i = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        step();
        step();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL reset_wen got %b exp 0", reg_wen_o); end
        tests++; if (reg_waddr_o !== 5'd0) begin fails++; $display("FAIL reset_waddr got %h exp 0", reg_waddr_o); end
        tests++; if (reg_wdata_o !== 32'd0) begin fails++; $display("FAIL reset_wdata got %h exp 0", reg_wdata_o); end
        tests++; if (busy_mask_o !== 32'd0) begin fails++; $display("FAIL reset_busy got %h exp 0", busy_mask_o); end
        tests++; if (lsu_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", lsu_ready_o); end
        rst = 1;
        step();
    endtask

    task automatic test_ex_write();
        ex_wen_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'h12345678;
        #1;
        tests++; if (ex_stall_o !== 1'b0) begin fails++; $display("FAIL ex_stall got %b exp 0", ex_stall_o); end
        step();
        idle();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd5, 32'h12345678})
            begin fails++; $display("FAIL ex_write got %b/%0d/%h exp 1/5/12345678", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        step();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b0, 5'd5, 32'h12345678})
            begin fails++; $display("FAIL ex_hold got %b/%0d/%h exp 0/5/12345678", reg_wen_o, reg_waddr_o, reg_wdata_o); end
    endtask

    task automatic test_issue();
        pend_set_i = 1; pend_rd_i = 7;
        step();
        idle();
        tests++; if (busy_mask_o !== 32'h80) begin fails++; $display("FAIL issue_set got %h exp 80", busy_mask_o); end
        step();
        step();
        lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'hDEADBEEF;
        #1;
        tests++; if (lsu_ready_o !== 1'b1) begin fails++; $display("FAIL issue_ready got %b exp 1", lsu_ready_o); end
        step();
        idle();
        tests++; if (reg_wen_o !== 1'b0 || busy_mask_o !== 32'h80)
            begin fails++; $display("FAIL issue_c4 got %b/%h exp 0/80", reg_wen_o, busy_mask_o); end
        step();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd7, 32'hDEADBEEF})
            begin fails++; $display("FAIL issue_write got %b/%0d/%h exp 1/7/deadbeef", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        tests++; if (busy_mask_o !== 32'h0) begin fails++; $display("FAIL issue_clear got %h exp 0", busy_mask_o); end
        step();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL issue_after got %b exp 0", reg_wen_o); end
    endtask

    task automatic test_contention();
        lsu_valid_i = 1; lsu_waddr_i = 3; lsu_wdata_i = 32'hA;
        step();
        idle();
        ex_wen_i = 1; ex_waddr_i = 4; ex_wdata_i = 32'hB;
        step();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd4, 32'hB})
            begin fails++; $display("FAIL cont_x4 got %b/%0d/%h exp 1/4/b", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        ex_waddr_i = 6; ex_wdata_i = 32'hC;
        step();
        idle();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd6, 32'hC})
            begin fails++; $display("FAIL cont_x6 got %b/%0d/%h exp 1/6/c", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        step();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd3, 32'hA})
            begin fails++; $display("FAIL cont_x3 got %b/%0d/%h exp 1/3/a", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            ex_wen_i = 1; ex_waddr_i = 5'(20 + i); ex_wdata_i = 32'h100 + 32'(i);
            lsu_valid_i = 1; lsu_waddr_i = 5'(10 + i); lsu_wdata_i = 32'h1000 + 32'(i);
            step();
        end
        ex_waddr_i = 24; ex_wdata_i = 32'h104;
        lsu_waddr_i = 14; lsu_wdata_i = 32'h1004;
        #1;
        tests++; if (lsu_ready_o !== 1'b0 || ex_stall_o !== 1'b1)
            begin fails++; $display("FAIL fill_full got ready %b stall %b exp 0/1", lsu_ready_o, ex_stall_o); end
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd23, 32'h103})
            begin fails++; $display("FAIL fill_ex23 got %b/%0d/%h exp 1/23/103", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        step();
        lsu_valid_i = 0;
        #1;
        tests++; if (lsu_ready_o !== 1'b1 || ex_stall_o !== 1'b0)
            begin fails++; $display("FAIL fill_drain got ready %b stall %b exp 1/0", lsu_ready_o, ex_stall_o); end
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd10, 32'h1000})
            begin fails++; $display("FAIL fill_head got %b/%0d/%h exp 1/10/1000", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        step();
        idle();
        tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd24, 32'h104})
            begin fails++; $display("FAIL fill_ex24 got %b/%0d/%h exp 1/24/104", reg_wen_o, reg_waddr_o, reg_wdata_o); end
        for (int i = 1; i < 4; i++) begin
            step();
            tests++; if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'(10 + i), 32'h1000 + 32'(i)})
                begin fails++; $display("FAIL fill_order%0d got %b/%0d/%h exp 1/%0d/%h", i, reg_wen_o, reg_waddr_o, reg_wdata_o, 10 + i, 32'h1000 + 32'(i)); end
        end
        step();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL fill_end got %b exp 0", reg_wen_o); end
    endtask

    task automatic test_set_clear();
        lsu_valid_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h99;
        step();
        idle();
        pend_set_i = 1; pend_rd_i = 9;
        step();
        idle();
        tests++; if ({reg_wen_o, reg_waddr_o} !== {1'b1, 5'd9})
            begin fails++; $display("FAIL setclr_write got %b/%0d exp 1/9", reg_wen_o, reg_waddr_o); end
        tests++; if (busy_mask_o !== 32'h200) begin fails++; $display("FAIL setclr_busy got %h exp 200", busy_mask_o); end
        step();
    endtask

    task automatic test_x0();
        ex_wen_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'hFF;
        lsu_valid_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 32'hEE;
        pend_set_i = 1; pend_rd_i = 0;
        #1;
        tests++; if (lsu_ready_o !== 1'b1 || ex_stall_o !== 1'b0)
            begin fails++; $display("FAIL x0_hs got ready %b stall %b exp 1/0", lsu_ready_o, ex_stall_o); end
        step();
        idle();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL x0_ex got %b exp 0", reg_wen_o); end
        tests++; if (busy_mask_o !== 32'h200) begin fails++; $display("FAIL x0_busy got %h exp 200", busy_mask_o); end
        step();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL x0_lsu got %b exp 0", reg_wen_o); end
    endtask

    task automatic test_mid_reset();
        lsu_valid_i = 1; lsu_waddr_i = 8; lsu_wdata_i = 32'h88;
        pend_set_i = 1; pend_rd_i = 8;
        step();
        idle();
        ex_wen_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'h22;
        rst = 0;
        step();
        idle();
        tests++; if ({reg_wen_o, busy_mask_o, lsu_ready_o} !== {1'b0, 32'h0, 1'b1})
            begin fails++; $display("FAIL midrst got wen %b busy %h ready %b exp 0/0/1", reg_wen_o, busy_mask_o, lsu_ready_o); end
        rst = 1;
        step();
        step();
        tests++; if (reg_wen_o !== 1'b0) begin fails++; $display("FAIL midrst_drop got %b exp 0", reg_wen_o); end
    endtask

    initial begin
        test_reset();
        test_ex_write();
        test_issue();
        test_contention();
        test_fill();
        test_set_clear();
        test_x0();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
